// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the set-2 make-code to ASCII table
// for the PS/2 key-event controller.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // Returns 0 for codes with no printable/control mapping; letters are
  // shifted to uppercase when upper is set, everything else ignores it.
  function automatic logic [7:0] sc_to_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] lc;
    logic       letter;
    lc = 8'h00;
    case (code)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      8'h16: lc = "1";  8'h1E: lc = "2";  8'h26: lc = "3";  8'h25: lc = "4";
      8'h2E: lc = "5";  8'h36: lc = "6";  8'h3D: lc = "7";  8'h3E: lc = "8";
      8'h46: lc = "9";  8'h45: lc = "0";
      8'h70: lc = "0";  8'h69: lc = "1";  8'h72: lc = "2";  8'h7A: lc = "3";
      8'h6B: lc = "4";  8'h73: lc = "5";  8'h74: lc = "6";  8'h6C: lc = "7";
      8'h75: lc = "8";  8'h7D: lc = "9";
      8'h29: lc = 8'h20;
      8'h5A: lc = 8'h0D;
      8'h66: lc = 8'h08;
      default: lc = 8'h00;
    endcase
    letter = (lc >= 8'h61) && (lc <= 8'h7A);
    return (letter && upper) ? (lc - 8'h20) : lc;
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Key-event read port: valid/ready handshake carrying {scan, ascii} of the FIFO head.
interface ps2_key_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_ascii;
  logic [7:0] evt_scan;

  modport master (output evt_valid, output evt_ascii, output evt_scan, input evt_ready);
  modport slave  (input evt_valid, input evt_ascii, input evt_scan, output evt_ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with occupancy count; head data reads as zero when empty.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO only lands when the same edge frees a slot.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: the storage array is deliberately not reset; pointers and count alone
  // decide which entries are live, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 key-event controller: prefix FSM, Shift/Caps tracking, ASCII
// translation and buffering of key events into a valid/ready FIFO.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_valid,
  input  logic [7:0]             scan_code,
  input  logic                   clr_ovf,
  ps2_key_ctrl_if.master         evt,
  output logic                   shift,
  output logic                   caps,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] count
);
  state_t     r_state, w_state_nxt;
  logic       r_lshift, r_rshift, r_caps, r_caps_held, r_ovf;
  logic       w_lshift_nxt, w_rshift_nxt, w_caps_nxt, w_caps_held_nxt;
  logic       w_make, w_break, w_ext;
  logic       w_push, w_pop, w_drop, w_full, w_empty;
  logic [7:0] w_ascii;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_break     = 1'b0;
    w_ext       = 1'b0;
    if (scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (scan_code == SC_EXT)      w_state_nxt = ST_EXT;
          else if (scan_code == SC_BRK) w_state_nxt = ST_BRK;
          else                          w_make      = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == SC_BRK)      w_state_nxt = ST_EXT_BRK;
          else if (scan_code != SC_EXT) begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (scan_code == SC_EXT) w_state_nxt = ST_EXT_BRK;
          else begin
            w_break     = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_break     = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Modifiers react only to non-extended codes; E0 12 (fake shift) falls through.
  always_comb begin
    w_lshift_nxt    = r_lshift;
    w_rshift_nxt    = r_rshift;
    w_caps_nxt      = r_caps;
    w_caps_held_nxt = r_caps_held;
    w_ascii         = 8'h00;
    w_push          = 1'b0;
    if (w_make && !w_ext) begin
      case (scan_code)
        SC_LSHIFT: w_lshift_nxt = 1'b1;
        SC_RSHIFT: w_rshift_nxt = 1'b1;
        SC_CAPS: begin
          if (!r_caps_held) w_caps_nxt = ~r_caps;
          w_caps_held_nxt = 1'b1;
        end
        default: begin
          w_ascii = sc_to_ascii(scan_code, (r_lshift | r_rshift) ^ r_caps);
          w_push  = (w_ascii != 8'h00);
        end
      endcase
    end else if (w_make && w_ext && scan_code == SC_ENTER) begin
      w_ascii = 8'h0D;
      w_push  = 1'b1;
    end else if (w_break && !w_ext) begin
      case (scan_code)
        SC_LSHIFT: w_lshift_nxt    = 1'b0;
        SC_RSHIFT: w_rshift_nxt    = 1'b0;
        SC_CAPS:   w_caps_held_nxt = 1'b0;
        default:   w_push          = 1'b0;
      endcase
    end
  end

  assign w_pop  = ~w_empty & evt.evt_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lshift    <= w_lshift_nxt;
      r_rshift    <= w_rshift_nxt;
      r_caps      <= w_caps_nxt;
      r_caps_held <= w_caps_held_nxt;
      // A fresh drop wins over a simultaneous clear.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  ps2_evt_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({scan_code, w_ascii}),
    .i_pop   (w_pop),
    .o_data  ({evt.evt_scan, evt.evt_ascii}),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt.evt_valid = ~w_empty;
  assign shift         = r_lshift | r_rshift;
  assign caps          = r_caps;
  assign ovf           = r_ovf;

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Key-event controller between the PS/2 scan-code receiver and the consumer (CPU MMIO port or display logic). It takes the receiver's one-cycle scan-code strobe and tracks the set-2 prefix sequence (E0 extended, F0 break). It keeps modifier state (Shift, Caps Lock), translates make codes to ASCII and buffers the resulting key events in a FIFO with a valid/ready read port.

## Interface
- DEPTH, 8, event FIFO entries; power of two, ≥2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- scan_valid  in  1  one-cycle strobe: scan_code holds a new byte
- scan_code  in  8  received scan-code byte
- evt_ready  in  1  consumer accepts the head event
- clr_ovf  in  1  clears the sticky overflow flag
- evt_valid  out  1  FIFO non-empty
- evt_ascii  out  8  ASCII of the head event
- evt_scan  out  8  raw make code of the head event
- shift  out  1  a Shift key is held (L 0x12 or R 0x59)
- caps  out  1  Caps Lock toggle state
- ovf  out  1  sticky: an event was dropped because the FIFO was full
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FSM states:
  - IDLE
  - EXT: E0 seen
  - BRK: F0 seen
  - EXT_BRK: E0 then F0 seen
- FSM transitions, evaluated only on a scan_valid cycle:
  - IDLE: E0→EXT; F0→BRK; any other byte → make(code, ext=0), stay in IDLE
  - EXT: F0→EXT_BRK; E0→EXT; any other byte → make(code, ext=1), then IDLE
  - BRK: E0→EXT_BRK (tolerated); any other byte → break(code, ext=0), then IDLE
  - EXT_BRK: any byte → break(code, ext=1), then IDLE
- make, ext=0:
  - 0x12 or 0x59 sets that key's held bit.
  - 0x58 toggles caps only if caps_held=0, then sets caps_held (typematic repeat does not re-toggle).
  - Otherwise translate; push {code, ascii} if ascii≠0.
- break, ext=0: 0x12/0x59 clears its held bit; 0x58 clears caps_held. No push.
- make, ext=1: only 0x5A (keypad Enter) pushes ascii 0x0D. Other codes are ignored, including the fake shift E0 12. No modifier change.
- break, ext=1: ignored.
- shift = L_held | R_held.
- Translation:
  - Letters a–z (0x1C a, 0x32 b, 0x21 c, 0x23 d, 0x24 e, 0x2B f, 0x34 g, 0x33 h, 0x43 i, 0x3B j, 0x42 k, 0x4B l, 0x3A m, 0x31 n, 0x44 o, 0x4D p, 0x15 q, 0x2D r, 0x1B s, 0x2C t, 0x3C u, 0x2A v, 0x1D w, 0x22 x, 0x35 y, 0x1A z): lowercase, uppercase (−0x20) when shift XOR caps.
  - Top-row digits (0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46,0x45 → '1'..'9','0'): unaffected by modifiers.
  - Keypad digits (0x70 '0', 0x69,0x72,0x7A,0x6B,0x73,0x74,0x6C,0x75,0x7D → '1'..'9'): unaffected by modifiers.
  - 0x29→0x20; 0x5A→0x0D; 0x66→0x08.
  - All else → 0, no push.
- FIFO rules:
  - Pop when evt_valid & evt_ready.
  - Push when full and no pop in the same cycle: drop the event, set ovf.
  - Push and pop in the same cycle while full: both take effect, count unchanged.
  - Push and pop in the same cycle while empty: push only (no pop, evt_valid=0 that cycle).
  - Pointers wrap modulo DEPTH.
- ovf clears on clr_ovf. If clr_ovf and a new overflow occur in the same cycle, ovf stays 1.

## Timing
- Reset (async assert, released synchronously to clk):
  - FSM state IDLE
  - shift=0, caps=0, caps_held=0
  - FIFO empty: evt_valid=0, count=0
  - ovf=0
  - evt_ascii=0, evt_scan=0
- A scan_valid byte is consumed at the edge where it is sampled. A resulting event is written at that edge; evt_valid and count update the next cycle (1-cycle latency).
- shift and caps update on the same edge as the FSM.
- evt_ascii and evt_scan come from the registered FIFO head. They are stable while evt_valid=1 and evt_ready=0.
- scan_valid has no backpressure. Back-to-back strobes on consecutive cycles are handled.
- Reset mid-prefix (e.g. after F0) returns to IDLE. The next byte is treated as a make.

## Structure
- Package ps2_pkg holds:
  - state enum
  - prefix constants SC_EXT=0xE0, SC_BRK=0xF0
  - modifier codes SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CAPS=0x58
  - a translation function returning ascii for (code, upper)
- Sub-module ps2_evt_fifo: synchronous 16-bit FIFO with DEPTH parameter, count, full/empty.
- FSM and modifier tracking live in ps2_key_ctrl.

## Test plan
- Make 0x1C then F0 1C, evt_ready=1 → one event {0x1C, 0x61}; the break produces no event.
- 12, 1C, F0 12, 1C → events 0x41 then 0x61; shift=1 then 0.
- 58, 58 (repeat), F0 58, 1C → caps=1 after the first 58 only, event 0x41. Then 58, F0 58, 1C → caps=0, event 0x61.
- E0 5A → event {0x5A, 0x0D}. E0 12, 1C → shift stays 0, event 0x61. E0 F0 5A → no event.
- DEPTH=8, evt_ready=0, nine 0x16 makes → count=8, ovf=1, head 0x31, ninth dropped. Pop with a simultaneous push while full → count stays 8. clr_ovf → ovf=0.
- Send F0, assert reset, release, then send 0x1C → FIFO empty after reset; one event 0x61 is produced (not treated as a break).
